// File: rtl/mem_stall_controller.sv
// mem_stall_controller: stalls the pipeline while instruction/data memory accesses are outstanding.
//   Parameters:
//     TIMEOUT_CYCLES : wait-cycle count at which a hung access is flagged
//     CNT_WIDTH      : width of the stall-cycle performance counter
//   Ports:
//     clk, rst           : clock, synchronous active-high reset
//     imem_req           : fetch stage wants an instruction this step
//     dmem_read_req      : MEM stage wants a data read
//     dmem_write_req     : MEM stage wants a data write (wins over read)
//     imem_resp          : instruction memory completion pulse
//     dmem_resp          : data memory completion pulse
//     imem_read          : instruction read strobe
//     dmem_read          : data read strobe
//     dmem_write         : data write strobe
//     stall_pipeline     : freeze pipeline registers and PC
//     stall_cycles       : saturating count of stalled cycles
//     mem_timeout        : sticky hung-access flag
//     state_dbg          : FSM state (IDLE=0, WAIT_BOTH=1, WAIT_I=2, WAIT_D=3)
module mem_stall_controller #(
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 imem_req,
    input  logic                 dmem_read_req,
    input  logic                 dmem_write_req,
    input  logic                 imem_resp,
    input  logic                 dmem_resp,
    output logic                 imem_read,
    output logic                 dmem_read,
    output logic                 dmem_write,
    output logic                 stall_pipeline,
    output logic [CNT_WIDTH-1:0] stall_cycles,
    output logic                 mem_timeout,
    output logic [1:0]           state_dbg
);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BOTH = 2'd1,
        WAIT_I    = 2'd2,
        WAIT_D    = 2'd3
    } state_t;
    state_t               state_q, state_d;
    logic                 i_done_q, i_done_d;
    logic                 d_done_q, d_done_d;
    logic                 timeout_q, timeout_d;
    logic [WW-1:0]        wait_q, wait_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 d_req, d_pend, i_out, d_out;
    always_comb begin
        d_req          = dmem_read_req | dmem_write_req;
        d_pend         = d_req & ~d_done_q;
        imem_read      = imem_req & ~i_done_q;
        dmem_write     = dmem_write_req & ~d_done_q;
        dmem_read      = dmem_read_req & ~dmem_write_req & ~d_done_q;
        // a port still outstanding after this cycle's response
        i_out          = imem_read & ~imem_resp;
        d_out          = d_pend & ~dmem_resp;
        stall_pipeline = i_out | d_out;
        // done flags only live while stalled; an unstalled cycle starts a fresh step
        i_done_d       = stall_pipeline & (i_done_q | (imem_read & imem_resp));
        d_done_d       = stall_pipeline & (d_done_q | (d_pend & dmem_resp));
        state_d        = i_out ? (d_out ? WAIT_BOTH : WAIT_I) : (d_out ? WAIT_D : IDLE);
        // wait counter parks at the limit so it can never wrap back under it
        wait_d         = !stall_pipeline ? '0 :
                         (wait_q == WW'(TIMEOUT_CYCLES)) ? wait_q : wait_q + 1'b1;
        timeout_d      = timeout_q | (wait_d == WW'(TIMEOUT_CYCLES));
        cnt_d          = (stall_pipeline && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            i_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
            wait_q    <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            i_done_q  <= i_done_d;
            d_done_q  <= d_done_d;
            wait_q    <= wait_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end
    assign stall_cycles = cnt_q;
    assign mem_timeout  = timeout_q;
    assign state_dbg    = state_q;
endmodule

// File: tb/tb_mem_stall_controller.sv
// tb_mem_stall_controller: directed self-checking bench for mem_stall_controller.
module tb_mem_stall_controller;
    localparam int CW = 8;
    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          imem_req = 1'b0, dmem_read_req = 1'b0, dmem_write_req = 1'b0;
    logic          imem_resp = 1'b0, dmem_resp = 1'b0;
    logic          imem_read, dmem_read, dmem_write, stall_pipeline, mem_timeout;
    logic [CW-1:0] stall_cycles;
    logic [1:0]    state_dbg;
    int            n_cmp = 0;
    int            n_bad = 0;

    mem_stall_controller #(.TIMEOUT_CYCLES(1023), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .dmem_read_req(dmem_read_req), .dmem_write_req(dmem_write_req),
        .imem_resp(imem_resp), .dmem_resp(dmem_resp),
        .imem_read(imem_read), .dmem_read(dmem_read), .dmem_write(dmem_write),
        .stall_pipeline(stall_pipeline), .stall_cycles(stall_cycles),
        .mem_timeout(mem_timeout), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic im, input logic rd, input logic wr, input logic ir, input logic dr);
        imem_req = im; dmem_read_req = rd; dmem_write_req = wr; imem_resp = ir; dmem_resp = dr;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0);
        rst = 1'b1;
        nxt();
        nxt();
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        @(negedge clk);
        chk("rst_state", state_dbg, 0);
        chk("rst_cnt", stall_cycles, 0);
        chk("rst_to", mem_timeout, 0);
        chk("rst_stall", stall_pipeline, 0);

        // instruction miss answered in cycle 3
        nxt();
        drive(1, 0, 0, 0, 0);
        @(negedge clk);
        chk("i_c0_stall", stall_pipeline, 1);
        chk("i_c0_rd", imem_read, 1);
        chk("i_c0_state", state_dbg, 0);
        nxt();
        @(negedge clk);
        chk("i_c1_state", state_dbg, 2);
        nxt();
        @(negedge clk);
        chk("i_c2_stall", stall_pipeline, 1);
        nxt();
        drive(1, 0, 0, 1, 0);
        @(negedge clk);
        chk("i_c3_stall", stall_pipeline, 0);
        chk("i_c3_rd", imem_read, 1);
        chk("i_c3_state", state_dbg, 2);
        nxt();
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("i_c4_state", state_dbg, 0);
        chk("i_c4_cnt", stall_cycles, 3);

        // both ports, data answered cycle 2, instruction cycle 5
        do_reset();
        drive(1, 1, 0, 0, 0);
        @(negedge clk);
        chk("b_c0_drd", dmem_read, 1);
        nxt();
        @(negedge clk);
        chk("b_c1_state", state_dbg, 1);
        nxt();
        drive(1, 1, 0, 0, 1);
        @(negedge clk);
        chk("b_c2_drd", dmem_read, 1);
        chk("b_c2_stall", stall_pipeline, 1);
        nxt();
        drive(1, 1, 0, 0, 0);
        @(negedge clk);
        chk("b_c3_drd", dmem_read, 0);
        chk("b_c3_state", state_dbg, 2);
        chk("b_c3_stall", stall_pipeline, 1);
        nxt();
        @(negedge clk);
        chk("b_c4_irq", imem_read, 1);
        nxt();
        drive(1, 1, 0, 1, 0);
        @(negedge clk);
        chk("b_c5_stall", stall_pipeline, 0);
        nxt();
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("b_c6_state", state_dbg, 0);
        chk("b_c6_cnt", stall_cycles, 5);

        // zero-wait memory on both ports
        do_reset();
        drive(1, 0, 1, 1, 1);
        @(negedge clk);
        chk("z_stall", stall_pipeline, 0);
        chk("z_irq", imem_read, 1);
        chk("z_dwr", dmem_write, 1);
        nxt();
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("z_cnt", stall_cycles, 0);
        chk("z_state", state_dbg, 0);

        // illegal read+write: write wins
        do_reset();
        drive(0, 1, 1, 0, 0);
        @(negedge clk);
        chk("rw_dwr", dmem_write, 1);
        chk("rw_drd", dmem_read, 0);
        chk("rw_stall", stall_pipeline, 1);
        nxt();
        @(negedge clk);
        chk("rw_state", state_dbg, 3);
        nxt();
        drive(0, 1, 1, 0, 1);
        @(negedge clk);
        chk("rw_resp_stall", stall_pipeline, 0);
        nxt();
        drive(0, 0, 0, 0, 0);

        // reset in cycle 2 of a data wait
        do_reset();
        drive(0, 1, 0, 0, 0);
        nxt();
        nxt();
        rst = 1'b1;
        @(negedge clk);
        chk("rd_c2_state", state_dbg, 3);
        chk("rd_c2_cnt", stall_cycles, 2);
        chk("rd_c2_drd", dmem_read, 1);
        nxt();
        rst = 1'b0;
        @(negedge clk);
        chk("rd_c3_state", state_dbg, 0);
        chk("rd_c3_cnt", stall_cycles, 0);
        chk("rd_c3_drd", dmem_read, 1);
        chk("rd_c3_stall", stall_pipeline, 1);

        // reset after data answered: read strobe comes back from cleared d_done
        do_reset();
        drive(1, 1, 0, 0, 1);
        nxt();
        drive(1, 1, 0, 0, 0);
        @(negedge clk);
        chk("rr_drd_done", dmem_read, 0);
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        @(negedge clk);
        chk("rr_drd_back", dmem_read, 1);
        chk("rr_state", state_dbg, 0);

        // watchdog and counter saturation
        do_reset();
        drive(1, 0, 0, 0, 0);
        repeat (1022) nxt();
        @(negedge clk);
        chk("to_c1022", mem_timeout, 0);
        chk("to_c1022_state", state_dbg, 2);
        nxt();
        @(negedge clk);
        chk("to_c1023", mem_timeout, 1);
        chk("to_c1023_stall", stall_pipeline, 1);
        drive(1, 0, 0, 1, 0);
        #1;
        chk("to_resp_stall", stall_pipeline, 0);
        nxt();
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("to_sticky", mem_timeout, 1);
        chk("to_sat", stall_cycles, 255);
        nxt();
        drive(0, 1, 0, 0, 0);
        nxt();
        drive(0, 1, 0, 0, 1);
        @(negedge clk);
        chk("to_sat_hold", stall_cycles, 255);
        chk("to_still", mem_timeout, 1);
        do_reset();
        @(negedge clk);
        chk("to_clear", mem_timeout, 0);
        chk("to_cnt_clear", stall_cycles, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_stall_controller.md
MEM_STALL_CONTROLLER -- requirements
Module: mem_stall_controller

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1023: wait-cycle count at which the watchdog flags a hung access.
REQ-002 Parameter CNT_WIDTH, default 32: width of the stall-cycle performance counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 imem_req  input  1  fetch stage requests an instruction read this pipeline step (level).
REQ-006 dmem_read_req  input  1  MEM stage requests a data read (level).
REQ-007 dmem_write_req  input  1  MEM stage requests a data write (level).
REQ-008 imem_resp  input  1  instruction memory completion pulse.
REQ-009 dmem_resp  input  1  data memory completion pulse.
REQ-010 imem_read  output  1  read strobe to instruction memory.
REQ-011 dmem_read  output  1  read strobe to data memory.
REQ-012 dmem_write  output  1  write strobe to data memory.
REQ-013 stall_pipeline  output  1  freezes all pipeline registers and PC (consumed by hazard detection).
REQ-014 stall_cycles  output  CNT_WIDTH  saturating count of cycles with stall_pipeline high.
REQ-015 mem_timeout  output  1  sticky flag: a single wait reached TIMEOUT_CYCLES.
REQ-016 state_dbg  output  2  current FSM state: IDLE=0, WAIT_BOTH=1, WAIT_I=2, WAIT_D=3.

Function
REQ-017 Internal flags i_done, d_done mark a port already answered in the current pipeline step.
REQ-018 d_req = dmem_read_req | dmem_write_req; both high simultaneously is illegal; write takes priority and read strobe is suppressed.
REQ-019 imem_read = imem_req & ~i_done; dmem_write = dmem_write_req & ~d_done; dmem_read = dmem_read_req & ~dmem_write_req & ~d_done.
REQ-020 Strobes hold steady from issue until resp, including the resp cycle; deasserted the cycle after resp while still stalled.
REQ-021 stall_pipeline (combinational) = (imem_req & ~i_done & ~imem_resp) | (d_req & ~d_done & ~dmem_resp).
REQ-022 On a cycle with stall_pipeline high: i_done sets on imem_resp, d_done sets on dmem_resp.
REQ-023 On a cycle with stall_pipeline low: i_done and d_done clear (pipeline advances; next step starts fresh).
REQ-024 Responses arriving the same cycle as each other, or on a port's first request cycle, count immediately; zero-wait memory yields no stall.
REQ-025 resp on a port with no outstanding request (req low or done set) is ignored.
REQ-026 FSM next state from outstanding ports after this cycle's resp: both -> WAIT_BOTH; only I -> WAIT_I; only D -> WAIT_D; none -> IDLE.
REQ-027 Legal transitions: IDLE->any; WAIT_BOTH->WAIT_I (dmem_resp), WAIT_D (imem_resp), IDLE (both); WAIT_I/WAIT_D->IDLE on own resp, else hold.
REQ-028 WAIT_I/WAIT_D never return to WAIT_BOTH within one pipeline step.
REQ-029 Wait counter: increments each cycle stall_pipeline high, clears when low; at TIMEOUT_CYCLES sets mem_timeout, which stays set until rst.
REQ-030 stall_cycles increments by 1 per stalled cycle, saturates at all-ones, never wraps.
REQ-031 Requests changing mid-stall are not legal; the pipeline holds them stable because its registers are frozen.

Reset
REQ-032 rst high at a clock edge: state IDLE, i_done=d_done=0, wait counter 0, stall_cycles 0, mem_timeout 0.
REQ-033 Reset mid-wait abandons the outstanding access; outputs then follow REQ-019/021 from the cleared flags the next cycle.
REQ-034 Combinational outputs follow inputs during reset using the reset flag values.

Verification
REQ-035 imem_req=1, d_req=0, imem_resp at cycle 3 -> stall high cycles 0-2, low cycle 3, stall_cycles=3, state WAIT_I->IDLE.
REQ-036 imem_req=1, dmem_read_req=1, dmem_resp cycle 2, imem_resp cycle 5 -> dmem_read drops cycle 3, stall low at cycle 5, states WAIT_BOTH->WAIT_I->IDLE.
REQ-037 Both resps on first request cycle -> stall_pipeline never high, stall_cycles stays 0.
REQ-038 dmem_write_req and dmem_read_req both high -> dmem_write=1, dmem_read=0.
REQ-039 imem_req held, no resp for 1023 cycles -> mem_timeout=1 at cycle 1023, remains 1 after resp, cleared only by rst.
REQ-040 rst at cycle 2 of a WAIT_D wait -> next cycle state IDLE, counters 0, dmem strobe re-asserted from cleared d_done.
